ram_arbiter: RTL and testbench

Round-robin arbiter and access sequencer that shares the single-port 32x16 RAM between two requesters. Each requester presents a read or write request. The arbiter picks one winner, drives the RAM's write-enable, read-enable, address and data ports for exactly one cycle, and returns read data with a valid pulse. It sits between the two datapath clients and the RAM, and it is the only block that drives the RAM control ports.

---
 rtl/ram_arbiter.sv | 139 +++++++++++++
 tb/tb_ram_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin arbiter sequencing two requesters onto a single-port 32x16 RAM
module ram_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              ram_wrenable,
    output logic              ram_rdenable,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                winner_q, winner_d;
    logic                last_winner_q, last_winner_d;
    logic                ram_wrenable_q, ram_wrenable_d;
    logic                ram_rdenable_q, ram_rdenable_d;
    logic [ADDR_W-1:0]   ram_address_q, ram_address_d;
    logic [DATA_W-1:0]   ram_data_in_q, ram_data_in_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                rvalid0_q, rvalid0_d;
    logic                rvalid1_q, rvalid1_d;
    logic                pick;
    logic                pick_we;

    always_comb begin
        state_d        = state_q;
        winner_d       = winner_q;
        last_winner_d  = last_winner_q;
        ram_wrenable_d = 1'b0;
        ram_rdenable_d = 1'b0;
        ram_address_d  = ram_address_q;
        ram_data_in_d  = ram_data_in_q;
        rdata0_d       = rdata0_q;
        rdata1_d       = rdata1_q;
        rvalid0_d      = 1'b0;
        rvalid1_d      = 1'b0;
        pick           = 1'b0;
        pick_we        = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // Under contention the port that did not win last time goes first.
                    pick           = (req0 && req1) ? ~last_winner_q : req1;
                    pick_we        = pick ? we1 : we0;
                    winner_d       = pick;
                    last_winner_d  = pick;
                    ram_wrenable_d = pick_we;
                    ram_rdenable_d = ~pick_we;
                    ram_address_d  = pick ? addr1 : addr0;
                    ram_data_in_d  = pick ? wdata1 : wdata0;
                    state_d        = ACCESS;
                end
            end
            ACCESS: begin
                state_d = ram_wrenable_q ? IDLE : RDWAIT;
            end
            RDWAIT: begin
                if (winner_q) begin
                    rdata1_d  = ram_data_out;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = ram_data_out;
                    rvalid0_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            winner_q       <= 1'b0;
            last_winner_q  <= 1'b1;
            ram_wrenable_q <= 1'b0;
            ram_rdenable_q <= 1'b0;
            ram_address_q  <= '0;
            ram_data_in_q  <= '0;
            rdata0_q       <= '0;
            rdata1_q       <= '0;
            rvalid0_q      <= 1'b0;
            rvalid1_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            winner_q       <= winner_d;
            last_winner_q  <= last_winner_d;
            ram_wrenable_q <= ram_wrenable_d;
            ram_rdenable_q <= ram_rdenable_d;
            ram_address_q  <= ram_address_d;
            ram_data_in_q  <= ram_data_in_d;
            rdata0_q       <= rdata0_d;
            rdata1_q       <= rdata1_d;
            rvalid0_q      <= rvalid0_d;
            rvalid1_q      <= rvalid1_d;
        end
    end

    assign gnt0         = (state_q == ACCESS) && !winner_q;
    assign gnt1         = (state_q == ACCESS) && winner_q;
    assign busy         = (state_q != IDLE);
    assign rvalid0      = rvalid0_q;
    assign rvalid1      = rvalid1_q;
    assign rdata0       = rdata0_q;
    assign rdata1       = rdata1_q;
    assign ram_wrenable = ram_wrenable_q;
    assign ram_rdenable = ram_rdenable_q;
    assign ram_address  = ram_address_q;
    assign ram_data_in  = ram_data_in_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed and randomized checks of ram_arbiter against a transaction-level model
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req [2];
    logic        we [2];
    logic [4:0]  addr [2];
    logic [15:0] wdata [2];
    logic        gnt [2];
    logic        rvalid [2];
    logic [15:0] rdata [2];
    logic        busy;
    logic        wren, rden;
    logic [4:0]  ram_address;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;

    int n_checks = 0;
    int n_fail   = 0;

    ram_arbiter #(.DATA_W(16), .ADDR_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0         (req[0]),
        .req1         (req[1]),
        .we0          (we[0]),
        .we1          (we[1]),
        .addr0        (addr[0]),
        .addr1        (addr[1]),
        .wdata0       (wdata[0]),
        .wdata1       (wdata[1]),
        .gnt0         (gnt[0]),
        .gnt1         (gnt[1]),
        .rvalid0      (rvalid[0]),
        .rvalid1      (rvalid[1]),
        .rdata0       (rdata[0]),
        .rdata1       (rdata[1]),
        .busy         (busy),
        .ram_wrenable (wren),
        .ram_rdenable (rden),
        .ram_address  (ram_address),
        .ram_data_in  (ram_din),
        .ram_data_out (ram_dout)
    );

    always #5 clk = ~clk;

    // Environment RAM: single-port, registered read, no reset.
    logic [15:0] ram_mem [32];
    initial begin
        for (int i = 0; i < 32; i++) ram_mem[i] = 16'h0;
        ram_dout = 16'h0;
    end
    always @(posedge clk) begin
        if (wren) ram_mem[ram_address] <= ram_din;
        if (rden) ram_dout <= ram_mem[ram_address];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Transaction-level reference model
    typedef struct {
        int          due;
        logic [15:0] data;
        bit          known;
    } rd_t;

    rd_t         q0 [$];
    rd_t         q1 [$];
    logic [15:0] ref_mem [32];
    bit          written [32];
    bit          last_m;
    int          cyc;
    bit          pend [2];
    int          age [2];

    task automatic model_cycle(input bit gen);
        int  p;
        bit  exp_p;
        bit  exp_rv;
        rd_t e;
        @(negedge clk);
        cyc++;
        check("gnt_excl", 32'(gnt[0] & gnt[1]), 0);
        check("strobe_excl", 32'(wren & rden), 0);
        check("strobe_gnt", 32'(wren | rden), 32'(gnt[0] | gnt[1]));
        if (gnt[0] || gnt[1]) begin
            p     = gnt[1] ? 1 : 0;
            exp_p = (req[0] && req[1]) ? !last_m : req[1];
            check("arb_winner", 32'(p), 32'(exp_p));
            check("grant_we", 32'(wren), 32'(we[p]));
            check("grant_addr", 32'(ram_address), 32'(addr[p]));
            if (we[p]) begin
                check("grant_wdata", 32'(ram_din), 32'(wdata[p]));
                ref_mem[addr[p]] = wdata[p];
                written[addr[p]] = 1'b1;
            end else begin
                e.due   = cyc + 2;
                e.data  = ref_mem[addr[p]];
                e.known = written[addr[p]];
                if (p == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
            last_m = p[0];
        end
        exp_rv = (q0.size() > 0) && (q0[0].due == cyc);
        check("rvalid0", 32'(rvalid[0]), 32'(exp_rv));
        if (exp_rv) begin
            e = q0.pop_front();
            if (e.known) check("rdata0", 32'(rdata[0]), 32'(e.data));
        end
        exp_rv = (q1.size() > 0) && (q1[0].due == cyc);
        check("rvalid1", 32'(rvalid[1]), 32'(exp_rv));
        if (exp_rv) begin
            e = q1.pop_front();
            if (e.known) check("rdata1", 32'(rdata[1]), 32'(e.data));
        end
        for (int i = 0; i < 2; i++) begin
            if (pend[i] && !gnt[i]) begin
                age[i]++;
                check("wait_bound", 32'(age[i] > 8), 0);
            end
            if (gnt[i] || !pend[i]) begin
                age[i] = 0;
                if (gen && $urandom_range(0, 2) != 0) begin
                    pend[i]  = 1'b1;
                    req[i]   = 1'b1;
                    we[i]    = $urandom_range(0, 1) == 1;
                    addr[i]  = 5'($urandom_range(0, 31));
                    wdata[i] = 16'($urandom);
                end else begin
                    pend[i] = 1'b0;
                    req[i]  = 1'b0;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = 5'd0; wdata[i] = 16'h0;
        end
        tick(); tick();
        check("rst_ctrl", {25'd0, gnt[0], gnt[1], rvalid[0], rvalid[1], busy, wren, rden}, 0);
        check("rst_addr", 32'(ram_address), 0);
        check("rst_din", 32'(ram_din), 0);
        check("rst_rdata", {rdata[0], rdata[1]}, 0);
        rst = 1'b0;

        // Single write
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 5'd5; wdata[0] = 16'hA5A5;
        tick();
        check("w_gnt", {30'd0, gnt[1], gnt[0]}, 32'b01);
        check("w_strobes", {30'd0, wren, rden}, 32'b10);
        check("w_addr", 32'(ram_address), 5);
        check("w_din", 32'(ram_din), 32'hA5A5);
        check("w_busy", 32'(busy), 1);
        req[0] = 1'b0;
        tick();
        check("w_busy_end", 32'(busy), 0);

        // Port 1 write then read back
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 5'd31; wdata[1] = 16'h1234;
        tick();
        check("wr_gnt1", 32'(gnt[1]), 1);
        we[1] = 1'b0;
        tick();
        check("rd_idle_gnt1", 32'(gnt[1]), 0);
        tick();
        check("rd_gnt1", 32'(gnt[1]), 1);
        check("rd_strobe", {30'd0, wren, rden}, 32'b01);
        check("rd_addr", 32'(ram_address), 31);
        req[1] = 1'b0;
        tick();
        check("rdwait_strobes", {30'd0, wren, rden}, 0);
        check("rdwait_busy", 32'(busy), 1);
        check("rdwait_rvalid1", 32'(rvalid[1]), 0);
        tick();
        check("rd_rvalid1", 32'(rvalid[1]), 1);
        check("rd_rdata1", 32'(rdata[1]), 32'h1234);
        check("rd_rvalid0", 32'(rvalid[0]), 0);
        tick();
        check("rd_rvalid1_pulse", 32'(rvalid[1]), 0);
        check("rd_rdata1_hold", 32'(rdata[1]), 32'h1234);

        // Contention after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 5'd3; wdata[0] = 16'h0303;
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 5'd4; wdata[1] = 16'h0404;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("contend_gnt", {30'd0, gnt[1], gnt[0]},
                  (i % 4 == 0) ? 32'b01 : ((i % 4 == 2) ? 32'b10 : 32'b00));
        end
        req[0] = 1'b0; req[1] = 1'b0;
        tick();
        check("contend_idle", 32'(busy), 0);

        // Request held while busy
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 5'd5;
        tick();
        check("hold_gnt0", 32'(gnt[0]), 1);
        req[0] = 1'b0;
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 5'd7; wdata[1] = 16'h7777;
        tick();
        check("hold_rdwait_gnt1", 32'(gnt[1]), 0);
        tick();
        check("hold_rvalid0", 32'(rvalid[0]), 1);
        check("hold_rdata0", 32'(rdata[0]), 32'hA5A5);
        check("hold_idle_gnt1", 32'(gnt[1]), 0);
        tick();
        check("hold_gnt1", 32'(gnt[1]), 1);
        req[1] = 1'b0;
        tick();

        // Reset during RDWAIT
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 5'd9; wdata[0] = 16'hBEEF;
        tick();
        we[0] = 1'b0;
        tick();
        tick();
        check("rr_rden", 32'(rden), 1);
        req[0] = 1'b0;
        tick();
        check("rr_rdwait_busy", 32'(busy), 1);
        rst = 1'b1;
        tick();
        check("rr_rvalid0", 32'(rvalid[0]), 0);
        check("rr_rdata0", 32'(rdata[0]), 0);
        check("rr_busy", 32'(busy), 0);
        check("rr_gnt", {30'd0, gnt[1], gnt[0]}, 0);
        rst = 1'b0;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 5'd10; wdata[0] = 16'h1010;
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 5'd11; wdata[1] = 16'h1111;
        tick();
        check("rr_last_winner", {30'd0, gnt[1], gnt[0]}, 32'b01);
        req[0] = 1'b0; req[1] = 1'b0;
        tick(); tick();

        // Randomized traffic against the reference model
        for (int i = 0; i < 32; i++) begin
            ref_mem[i] = 16'h0;
            written[i] = 1'b0;
        end
        last_m = 1'b0;
        cyc    = 0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        age[0]  = 0;    age[1]  = 0;
        for (int i = 0; i < 2000; i++) model_cycle(1'b1);
        for (int i = 0; i < 20; i++) model_cycle(1'b0);
        check("drain_q0", 32'(q0.size()), 0);
        check("drain_q1", 32'(q1.size()), 0);
        check("drain_busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
